// File: rtl/updown_counter_pkg.sv
// Shared types and helpers for the up/down counter scheduler.
package updown_counter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  // Increment an index modulo n; used to advance the round-robin pointer.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/updown_counter_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// the pointer, wrapping around. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] pointer,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] index
);

  // Scan requesters starting at the pointer and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    int  idx;
    logic found;
    winner = '0;
    index  = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(pointer) + k) % NREQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        index       = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/updown_counter_sched.sv
// Round-robin scheduler sharing one external up/down counter among NREQ
// requesters. Each grant runs one job: load a start value, then count len
// steps in the requested direction. When idle the counter reloads its own
// value every cycle, which holds it.
module updown_counter_sched
  import updown_counter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]         req_updown,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    cnt_load,
  output logic                    cnt_updown,
  output logic [WIDTH-1:0]        cnt_data,
  input  logic [WIDTH-1:0]        cnt_count
);

  localparam int IDX_W = $clog2(NREQ);

  typedef struct packed {
    logic [WIDTH-1:0] start;
    logic             dir;
    logic [LEN_W-1:0] len;
  } job_t;

  state_e           state;
  job_t             job;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic [LEN_W-1:0] step;

  logic [NREQ-1:0]  win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req),
    .pointer (ptr),
    .winner  (win_onehot),
    .index   (win_idx)
  );

  assign any_req = |win_onehot;

  // Job FSM: arbitrate in IDLE, load, run len steps, then signal completion.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every register in this block updates
    // from values sampled before the edge, independent of statement order.
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      job   <= '0;
      step  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= win_idx;
            job.start <= req_data[win_idx*WIDTH +: WIDTH];
            job.dir   <= req_updown[win_idx];
            job.len   <= req_len[win_idx*LEN_W +: LEN_W];
            ptr       <= IDX_W'(wrap_inc(int'(win_idx), NREQ));
            state     <= LOAD;
          end
        end
        LOAD: begin
          step  <= job.len;
          state <= (job.len != '0) ? RUN : DONE;
        end
        RUN: begin
          step <= step - LEN_W'(1);
          if (step == LEN_W'(1)) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of counter pins and handshake pulses from registered state.
  always_comb begin
    gnt        = '0;
    done       = '0;
    busy       = (state != IDLE);
    cnt_load   = 1'b1;
    cnt_updown = 1'b0;
    cnt_data   = cnt_count;
    unique case (state)
      IDLE: ;
      LOAD: begin
        cnt_data   = job.start;
        gnt[owner] = 1'b1;
      end
      RUN: begin
        cnt_load   = 1'b0;
        cnt_updown = job.dir;
      end
      DONE: begin
        done[owner] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
